// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control path: state encodings,
// opcode constants, ALU control codes and datapath mux select values.
// Optional build macro: CTRL_ILLEGAL_TRAP_EN adds the TRAP state (11).
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
`ifdef CTRL_ILLEGAL_TRAP_EN
    , S_TRAP   = 4'd11
`endif
  } state_t;

  // Major opcodes of the supported instruction subset
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  // ALU operation codes seen by the datapath ALU
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Coarse ALU request from the FSM, refined by alu_decoder
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  // Result mux
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALU A mux
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  // ALU B mux
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Immediate extender format
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Immediate format implied by an opcode
  function automatic logic [1:0] imm_src_for(input logic [6:0] opcode);
    case (opcode)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: turns the FSM's coarse ALU request plus the
// instruction's funct fields into the 3-bit ALU operation code.
module alu_decoder
  import ctrl_pkg::*;
(
  input  alu_op_t     alu_op,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        op5,
  output logic [2:0]  alu_control
);

  // Only R-type (opcode bit 5 set) may select subtract through funct7
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: sequences the shared ALU and memory, stalls
// on in_mem_ready, and drives datapath enables and mux selects each cycle.
// Optional build macro: CTRL_ILLEGAL_TRAP_EN (unknown opcodes park in TRAP).
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic        in_funct7b5,
  input  logic        in_zero,
  input  logic        in_mem_ready,
  output logic        out_pc_write,
  output logic        out_ir_write,
  output logic        out_adr_src,
  output logic        out_mem_write,
  output logic        out_reg_write,
  output logic [1:0]  out_result_src,
  output logic [1:0]  out_alu_src_a,
  output logic [1:0]  out_alu_src_b,
  output logic [2:0]  out_alu_control,
  output logic [1:0]  out_imm_src,
  output logic [3:0]  out_state,
  output logic        out_illegal
);

  state_t  state_q;
  state_t  state_d;
  alu_op_t alu_op;
  logic    pc_write_c;
  logic    ir_write_c;
  logic    mem_write_c;
  logic    reg_write_c;

  // State register, cleared asynchronously so a reset aborts any instruction
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= state_t'(RESET_STATE);
    else        state_q <= state_d;
  end

  // Next-state and Moore output decode; enables default off in every state
  always_comb begin
    state_d        = S_FETCH;
    pc_write_c     = 1'b0;
    ir_write_c     = 1'b0;
    mem_write_c    = 1'b0;
    reg_write_c    = 1'b0;
    out_adr_src    = 1'b0;
    out_result_src = RES_ALUOUT;
    out_alu_src_a  = SRCA_PC;
    out_alu_src_b  = SRCB_RS2;
    out_imm_src    = IMM_I;
    alu_op         = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        out_alu_src_b  = SRCB_FOUR;
        out_result_src = RES_ALURESULT;
        pc_write_c     = in_mem_ready;
        ir_write_c     = in_mem_ready;
        state_d        = in_mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        out_alu_src_a = SRCA_OLDPC;
        out_alu_src_b = SRCB_IMM;
        out_imm_src   = imm_src_for(in_opcode);
        case (in_opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXEC_R;
          OP_I:         state_d = S_EXEC_I;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
`ifdef CTRL_ILLEGAL_TRAP_EN
          default:      state_d = S_TRAP;
`else
          default:      state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        out_alu_src_a = SRCA_RS1;
        out_alu_src_b = SRCB_IMM;
        out_imm_src   = imm_src_for(in_opcode);
        if (in_opcode == OP_LW)      state_d = S_MEMREAD;
        else if (in_opcode == OP_SW) state_d = S_MEMWRITE;
        else                         state_d = S_FETCH;
      end
      S_MEMREAD: begin
        out_adr_src = 1'b1;
        state_d     = in_mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        out_result_src = RES_MEMDATA;
        reg_write_c    = 1'b1;
        state_d        = S_FETCH;
      end
      S_MEMWRITE: begin
        out_adr_src = 1'b1;
        mem_write_c = 1'b1;
        state_d     = in_mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXEC_R: begin
        out_alu_src_a = SRCA_RS1;
        out_alu_src_b = SRCB_RS2;
        alu_op        = ALUOP_FUNCT;
        state_d       = S_ALUWB;
      end
      S_EXEC_I: begin
        out_alu_src_a = SRCA_RS1;
        out_alu_src_b = SRCB_IMM;
        out_imm_src   = imm_src_for(in_opcode);
        alu_op        = ALUOP_FUNCT;
        state_d       = S_ALUWB;
      end
      S_ALUWB: begin
        out_result_src = RES_ALUOUT;
        reg_write_c    = 1'b1;
        state_d        = S_FETCH;
      end
      S_BEQ: begin
        out_alu_src_a  = SRCA_RS1;
        out_alu_src_b  = SRCB_RS2;
        alu_op         = ALUOP_SUB;
        out_result_src = RES_ALUOUT;
        pc_write_c     = in_zero;
        state_d        = S_FETCH;
      end
      S_JAL: begin
        out_alu_src_a  = SRCA_OLDPC;
        out_alu_src_b  = SRCB_FOUR;
        out_result_src = RES_ALUOUT;
        pc_write_c     = 1'b1;
        state_d        = S_ALUWB;
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_TRAP: begin
        state_d = S_TRAP;
      end
`endif
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (in_funct3),
    .funct7b5    (in_funct7b5),
    .op5         (in_opcode[5]),
    .alu_control (out_alu_control)
  );

  // Architectural writes are masked while reset is held low
  assign out_pc_write  = pc_write_c  & reset;
  assign out_ir_write  = ir_write_c  & reset;
  assign out_mem_write = mem_write_c & reset;
  assign out_reg_write = reg_write_c & reset;
  assign out_state     = state_q;

`ifdef CTRL_ILLEGAL_TRAP_EN
  assign out_illegal = (state_q == S_TRAP);
`else
  assign out_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller.
// Optional build macro: CTRL_ILLEGAL_TRAP_EN selects the trap expectations.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic        in_funct7b5;
  logic        in_zero;
  logic        in_mem_ready;
  logic        out_pc_write;
  logic        out_ir_write;
  logic        out_adr_src;
  logic        out_mem_write;
  logic        out_reg_write;
  logic [1:0]  out_result_src;
  logic [1:0]  out_alu_src_a;
  logic [1:0]  out_alu_src_b;
  logic [2:0]  out_alu_control;
  logic [1:0]  out_imm_src;
  logic [3:0]  out_state;
  logic        out_illegal;

  int checkCount = 0;
  int errorCount = 0;

  multicycle_controller dut (
    .clk             (clk),
    .reset           (reset),
    .in_opcode       (in_opcode),
    .in_funct3       (in_funct3),
    .in_funct7b5     (in_funct7b5),
    .in_zero         (in_zero),
    .in_mem_ready    (in_mem_ready),
    .out_pc_write    (out_pc_write),
    .out_ir_write    (out_ir_write),
    .out_adr_src     (out_adr_src),
    .out_mem_write   (out_mem_write),
    .out_reg_write   (out_reg_write),
    .out_result_src  (out_result_src),
    .out_alu_src_a   (out_alu_src_a),
    .out_alu_src_b   (out_alu_src_b),
    .out_alu_control (out_alu_control),
    .out_imm_src     (out_imm_src),
    .out_state       (out_state),
    .out_illegal     (out_illegal)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [6:0] opcode, input logic [2:0] funct3,
                               input logic f7b5, input logic zero, input logic ready);
    in_opcode    = opcode;
    in_funct3    = funct3;
    in_funct7b5  = f7b5;
    in_zero      = zero;
    in_mem_ready = ready;
    #1;
  endtask

  // Advance one clock edge and settle just after the following falling edge
  task automatic nextCycle;
    @(negedge clk);
    #1;
  endtask

  logic [3:0] lwStates [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
  logic       lwRegWr  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [2:0] rFunct3  [3] = '{3'b010, 3'b110, 3'b111};
  logic [2:0] rAluCtl  [3] = '{3'b101, 3'b011, 3'b010};

  initial begin
    reset = 1'b0;
    applyStimulus(7'b0000000, 3'b000, 1'b0, 1'b0, 1'b1);
    nextCycle();
    checkOutput("rst_state", 32'(out_state), 0);
    checkOutput("rst_pcw", 32'(out_pc_write), 0);
    checkOutput("rst_irw", 32'(out_ir_write), 0);
    reset = 1'b1;
    #1;
    checkOutput("fetch_pcw", 32'(out_pc_write), 1);
    checkOutput("fetch_irw", 32'(out_ir_write), 1);
    checkOutput("fetch_srcb", 32'(out_alu_src_b), 2);
    checkOutput("fetch_res", 32'(out_result_src), 2);

    // lw with zero wait states: five cycles, write-back only in MEMWB
    applyStimulus(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("lw_state%0d", i), 32'(out_state), 32'(lwStates[i]));
      checkOutput($sformatf("lw_regw%0d", i), 32'(out_reg_write), 32'(lwRegWr[i]));
      if (i == 2) checkOutput("lw_srca", 32'(out_alu_src_a), 2);
      if (i == 3) checkOutput("lw_adrsrc", 32'(out_adr_src), 1);
      if (i == 4) checkOutput("lw_res", 32'(out_result_src), 1);
      if (i < 5) nextCycle();
    end

    // sw with memory stalled for three cycles in MEMWRITE
    applyStimulus(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b1);
    nextCycle();
    checkOutput("sw_imm", 32'(out_imm_src), 1);
    nextCycle();
    applyStimulus(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0);
    nextCycle();
    for (int k = 0; k < 4; k++) begin
      if (k == 3) applyStimulus(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b1);
      checkOutput($sformatf("sw_state%0d", k), 32'(out_state), 5);
      checkOutput($sformatf("sw_memw%0d", k), 32'(out_mem_write), 1);
      checkOutput($sformatf("sw_adr%0d", k), 32'(out_adr_src), 1);
      nextCycle();
    end
    checkOutput("sw_done_state", 32'(out_state), 0);
    checkOutput("sw_done_memw", 32'(out_mem_write), 0);

    // Reset asserted in the middle of a store
    nextCycle();
    nextCycle();
    applyStimulus(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0);
    nextCycle();
    checkOutput("abort_pre_memw", 32'(out_mem_write), 1);
    reset = 1'b0;
    #1;
    checkOutput("abort_memw", 32'(out_mem_write), 0);
    checkOutput("abort_state", 32'(out_state), 0);
    applyStimulus(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b1);
    nextCycle();
    checkOutput("abort_hold_state", 32'(out_state), 0);
    checkOutput("abort_hold_pcw", 32'(out_pc_write), 0);
    reset = 1'b1;
    #1;
    checkOutput("abort_rel_pcw", 32'(out_pc_write), 1);
    checkOutput("abort_rel_irw", 32'(out_ir_write), 1);

    // R-type sub
    applyStimulus(7'b0110011, 3'b000, 1'b1, 1'b0, 1'b1);
    nextCycle();
    nextCycle();
    checkOutput("sub_state", 32'(out_state), 6);
    checkOutput("sub_aluctl", 32'(out_alu_control), 1);
    checkOutput("sub_srca", 32'(out_alu_src_a), 2);
    checkOutput("sub_srcb", 32'(out_alu_src_b), 0);
    nextCycle();
    checkOutput("sub_wb_state", 32'(out_state), 8);
    checkOutput("sub_wb_regw", 32'(out_reg_write), 1);
    checkOutput("sub_wb_res", 32'(out_result_src), 0);
    nextCycle();
    checkOutput("sub_end_state", 32'(out_state), 0);

    // I-type addi with the same funct fields must still add
    applyStimulus(7'b0010011, 3'b000, 1'b1, 1'b0, 1'b1);
    nextCycle();
    nextCycle();
    checkOutput("addi_state", 32'(out_state), 7);
    checkOutput("addi_aluctl", 32'(out_alu_control), 0);
    checkOutput("addi_srcb", 32'(out_alu_src_b), 1);
    nextCycle();
    nextCycle();

    // Remaining R-type ALU functions
    for (int j = 0; j < 3; j++) begin
      applyStimulus(7'b0110011, rFunct3[j], 1'b0, 1'b0, 1'b1);
      nextCycle();
      nextCycle();
      checkOutput($sformatf("rfn_aluctl%0d", j), 32'(out_alu_control), 32'(rAluCtl[j]));
      nextCycle();
      nextCycle();
    end

    // beq taken then not taken
    for (int z = 1; z >= 0; z--) begin
      applyStimulus(7'b1100011, 3'b000, 1'b0, z[0], 1'b1);
      nextCycle();
      checkOutput("beq_imm", 32'(out_imm_src), 2);
      nextCycle();
      checkOutput("beq_state", 32'(out_state), 9);
      checkOutput($sformatf("beq_pcw_z%0d", z), 32'(out_pc_write), 32'(z));
      checkOutput("beq_aluctl", 32'(out_alu_control), 1);
      nextCycle();
      checkOutput("beq_end_state", 32'(out_state), 0);
    end

    // jal
    applyStimulus(7'b1101111, 3'b000, 1'b0, 1'b0, 1'b1);
    nextCycle();
    checkOutput("jal_imm", 32'(out_imm_src), 3);
    nextCycle();
    checkOutput("jal_state", 32'(out_state), 10);
    checkOutput("jal_pcw", 32'(out_pc_write), 1);
    checkOutput("jal_srca", 32'(out_alu_src_a), 1);
    checkOutput("jal_srcb", 32'(out_alu_src_b), 2);
    nextCycle();
    checkOutput("jal_wb_state", 32'(out_state), 8);
    nextCycle();
    checkOutput("jal_end_state", 32'(out_state), 0);

    // Unknown opcode
    applyStimulus(7'b0000000, 3'b000, 1'b0, 1'b0, 1'b1);
    nextCycle();
    checkOutput("ill_decode_state", 32'(out_state), 1);
    nextCycle();
`ifdef CTRL_ILLEGAL_TRAP_EN
    for (int t = 0; t < 10; t++) begin
      checkOutput($sformatf("trap_state%0d", t), 32'(out_state), 11);
      checkOutput($sformatf("trap_flag%0d", t), 32'(out_illegal), 1);
      checkOutput($sformatf("trap_pcw%0d", t), 32'(out_pc_write), 0);
      nextCycle();
    end
    reset = 1'b0;
    #1;
    checkOutput("trap_rst_state", 32'(out_state), 0);
    checkOutput("trap_rst_flag", 32'(out_illegal), 0);
    reset = 1'b1;
`else
    checkOutput("ill_state", 32'(out_state), 0);
    checkOutput("ill_flag", 32'(out_illegal), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control FSM that sequences a shared-ALU, shared-memory multi-cycle RV32I datapath, replacing the fixed single-cycle control.
- Holds the current instruction phase and drives the datapath enables and mux selects each cycle.
- Stalls on a memory ready handshake.
- Supported instructions: lw, sw, R-type ALU, I-type ALU, beq, jal.

Parameters:
- RESET_STATE, 4'd0, state entered on reset (FETCH).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_opcode  in  7  instr[6:0] from the instruction register.
- in_funct3  in  3  instr[14:12].
- in_funct7b5  in  1  instr[30].
- in_zero  in  1  ALU zero flag.
- in_mem_ready  in  1  memory has completed the current access.
- out_pc_write  out  1  PC register load enable.
- out_ir_write  out  1  instruction register and old-PC register load enable.
- out_adr_src  out  1  memory address select: 0=PC, 1=ALUOut.
- out_mem_write  out  1  data memory write enable.
- out_reg_write  out  1  register file write enable.
- out_result_src  out  2  result select: 00=ALUOut, 01=memory data, 10=ALU result.
- out_alu_src_a  out  2  ALU A select: 00=PC, 01=oldPC, 10=rs1.
- out_alu_src_b  out  2  ALU B select: 00=rs2, 01=immExt, 10=constant 4.
- out_alu_control  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- out_imm_src  out  2  extend select: 00=I, 01=S, 10=B, 11=J.
- out_state  out  4  current state, for debug.
- out_illegal  out  1  illegal-opcode flag (tied 0 unless CTRL_ILLEGAL_TRAP_EN).

Behaviour:
- State register: 4 bits, asynchronous clear to FETCH on reset low.
- While reset is low, out_pc_write, out_ir_write, out_reg_write and out_mem_write are forced 0.
- All other outputs are Moore-decoded from the state, except the handshake gating and beq gating described below.
- FETCH (0): adr_src=0, a=00, b=10, alu_op=add, result_src=10.
  - pc_write = ir_write = in_mem_ready.
  - Stay in FETCH while !in_mem_ready; go to DECODE when ready.
- DECODE (1): a=01, b=01, add, so the branch/jump target lands in ALUOut.
  - imm_src decoded from opcode: sw=01, beq=10, jal=11, else 00.
  - Next state: lw/sw → MEMADR; R-type (0110011) → EXEC_R; I-ALU (0010011) → EXEC_I; beq (1100011) → BEQ; jal (1101111) → JAL; any other opcode → FETCH (NOP).
- MEMADR (2): a=10, b=01, add. Go to MEMREAD if lw, MEMWRITE if sw.
- MEMREAD (3): adr_src=1. Hold while !in_mem_ready; go to MEMWB when ready.
- MEMWB (4): result_src=01, reg_write=1. Next state FETCH.
- MEMWRITE (5): adr_src=1, mem_write=1.
  - mem_write stays high until in_mem_ready, then go to FETCH.
- EXEC_R (6): a=10, b=00, alu_op=funct. Next state ALUWB.
- EXEC_I (7): a=10, b=01, alu_op=funct. Next state ALUWB.
- ALUWB (8): result_src=00, reg_write=1. Next state FETCH.
- BEQ (9): a=10, b=00, alu_op=sub, result_src=00.
  - pc_write = in_zero.
  - Next state FETCH.
- JAL (10): a=01, b=10, add, result_src=00, pc_write=1, so PC ← target while ALU computes oldPC+4.
  - Next state ALUWB.
- ALU decode for alu_op=funct, by funct3:
  - 000: sub if R-type and funct7b5, else add.
  - 010: slt. 110: or. 111: and.
  - Any other funct3: add.
- Unused states 11–15 (12–15 when trap is enabled) go to FETCH with all enables 0.
- Latency (with zero memory wait) is load 5, store 4, R/I 4, beq 3, jal 4 cycles. Each wait cycle adds 1.
- Reset asserted mid-instruction aborts the instruction immediately; no partial write is issued after reset assertion.

Optional Feature:
- CTRL_ILLEGAL_TRAP_EN defined:
  - An unknown opcode in DECODE goes to TRAP (11).
  - In TRAP, out_illegal=1 and all enables are 0.
  - TRAP holds until reset.
- CTRL_ILLEGAL_TRAP_EN undefined:
  - An unknown opcode goes to FETCH.
  - out_illegal is tied 0 and the TRAP state does not exist.

Decomposition:
- Shared package ctrl_pkg holds:
  - State encodings.
  - Opcode constants: OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL.
  - ALU control codes.
  - Mux select constants for result_src, alu_src_a, alu_src_b and imm_src.
- One sub-module, alu_decoder: combinational mapping of alu_op, funct3, funct7b5 and opcode[5] to out_alu_control.
- The FSM and output decode stay in multicycle_controller.

Test Plan:
- Reset low during MEMWRITE with mem_write=1 → mem_write drops 0 asynchronously and out_state=0. After release with ready=1: pc_write=1 and ir_write=1 in the first cycle.
- lw (opcode 0000011), ready always 1 → states 0,1,2,3,4,0; reg_write=1 only in state 4 with result_src=01.
- sw, ready low for 3 cycles in MEMWRITE → mem_write=1 for 4 cycles, adr_src=1, then FETCH.
- R-type sub (funct3=000, funct7b5=1) → alu_control=001 in EXEC_R. Same fields on I-type addi → 000.
- beq with zero=1 → pc_write=1 in BEQ. With zero=0 → pc_write=0. Both return to FETCH.
- Opcode 0000000 → FETCH without trap. With CTRL_ILLEGAL_TRAP_EN: state 11, out_illegal=1, stays there 10 cycles until reset.
